// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column multiplexing, frame-level
// debounce of single-key presses/releases, and a valid/ready key code output.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    // state    | meaning
    // S_IDLE   | no key down, waiting for a single-key frame
    // S_PRESS  | same single key seen for cnt consecutive frames
    // S_HELD   | press confirmed, key still down (no rollover)
    // S_REL    | empty frames seen for cnt consecutive frames
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_HELD  = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS);

    logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [1:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [15:0]   frame_q, frame_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          overrun_q, overrun_d;

    logic          sample, eval, confirm, single, none;
    logic [3:0]    rows_on, hit_code;
    logic [15:0]   spread, frame_now;
    logic [4:0]    pop;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        row_s1_d    = row_n;
        row_s2_d    = row_s1_q;
        col_d       = col_q;
        frame_d     = frame_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_held_d  = key_held_q;
        overrun_d   = 1'b0;
        confirm     = 1'b0;

        sample  = (dwell_q == DWELL_LAST);
        eval    = sample && (col_q == 2'd3);
        dwell_d = sample ? '0 : dwell_q + DW'(1);
        if (sample) begin
            col_d = col_q + 2'd1;
        end

        // Place each row's bit at row*4 and shift it over to the active column.
        rows_on   = ~row_s2_q;
        spread    = {3'b000, rows_on[3], 3'b000, rows_on[2],
                     3'b000, rows_on[1], 3'b000, rows_on[0]};
        frame_now = frame_q | (spread << col_q);
        if (sample) begin
            frame_d = eval ? '0 : frame_now;
        end

        pop      = '0;
        hit_code = '0;
        for (int i = 15; i >= 0; i--) begin
            pop = pop + {4'b0000, frame_now[i]};
            if (frame_now[i]) begin
                hit_code = 4'(i);
            end
        end
        single  = (pop == 5'd1);
        none    = (pop == 5'd0);
        cnt_inc = cnt_q + CNT_ONE;

        // Acceptance is applied before any confirm in the same cycle.
        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end

        if (eval) begin
            case (state_q)
                S_IDLE: begin
                    if (single) begin
                        cand_d = hit_code;
                        cnt_d  = CNT_ONE;
                        if (CNT_ONE == CNT_LAST) begin
                            confirm = 1'b1;
                        end else begin
                            state_d = S_PRESS;
                        end
                    end
                end
                S_PRESS: begin
                    if (single && hit_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            confirm = 1'b1;
                        end
                    end else if (single) begin
                        cand_d = hit_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_HELD: begin
                    if (none) begin
                        if (CNT_ONE == CNT_LAST) begin
                            state_d    = S_IDLE;
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                        end else begin
                            state_d = S_REL;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_REL: begin
                    if (none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_d    = S_IDLE;
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                        end
                    end else begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (confirm) begin
            state_d    = S_HELD;
            cnt_d      = '0;
            key_held_d = 1'b1;
            if (!key_valid_d) begin
                key_code_d  = hit_code;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            col_q       <= '0;
            dwell_q     <= '0;
            frame_q     <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            frame_q     <= frame_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix driven by the DUT's columns, a
// frame-level streak model checked every cycle, plus directed literal checks.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_n, col_n, key_code;
    logic       key_valid, key_held, overrun;
    logic       key_ready = 1'b0;
    logic [15:0] keys = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Matrix: a row reads low when any pressed key in it sits on the driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
        end
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .overrun(overrun)
    );

    // Reference model: cycle index since reset, frames built from the keys the
    // DUT saw two edges earlier, and press/release streaks over whole frames.
    int          m_cyc;
    logic [15:0] m_frame, m_k1, m_k2;
    bit          m_held;
    int          m_streak, m_rel;
    logic [3:0]  m_cand;
    logic        exp_valid, exp_held, exp_over;
    logic [3:0]  exp_code;

    initial begin : model
        int col, pop;
        logic [3:0] code;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_cyc = 0; m_frame = '0; m_k1 = '0; m_k2 = '0;
                m_held = 0; m_streak = 0; m_rel = 0; m_cand = '0;
                exp_valid = 0; exp_held = 0; exp_over = 0; exp_code = '0;
            end else begin
                exp_over = 0;
                if (exp_valid && key_ready) exp_valid = 0;
                col = (m_cyc / SD) % 4;
                if (m_cyc % SD == SD - 1) begin
                    for (int r = 0; r < 4; r++)
                        if (m_k2[r*4 + col]) m_frame[r*4 + col] = 1'b1;
                end
                if (m_cyc % FRAME == FRAME - 1) begin
                    pop  = $countones(m_frame);
                    code = '0;
                    for (int i = 15; i >= 0; i--)
                        if (m_frame[i]) code = 4'(i);
                    if (!m_held) begin
                        if (pop == 1) begin
                            if (m_streak > 0 && code == m_cand) m_streak++;
                            else begin m_cand = code; m_streak = 1; end
                            if (m_streak == DB) begin
                                m_held = 1; m_streak = 0; m_rel = 0; exp_held = 1;
                                if (exp_valid) exp_over = 1;
                                else begin exp_valid = 1; exp_code = m_cand; end
                            end
                        end else m_streak = 0;
                    end else begin
                        if (pop == 0) begin
                            m_rel++;
                            if (m_rel == DB) begin m_held = 0; exp_held = 0; m_rel = 0; end
                        end else m_rel = 0;
                    end
                    m_frame = '0;
                end
                m_k2 = m_k1;
                m_k1 = keys;
                m_cyc++;
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d, t=%0t)", nm, act, exp, m_cyc, $time);
        end
    endtask

    initial begin : compare
        logic [3:0] ec;
        forever begin
            @(negedge clk);
            ec = 4'b0001 << ((m_cyc / SD) % 4);
            chk("col_n", col_n, ~ec);
            chk("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
            chk("key_code", key_code, exp_code);
            chk("key_held", {3'b000, key_held}, {3'b000, exp_held});
            chk("overrun", {3'b000, overrun}, {3'b000, exp_over});
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (m_cyc != n && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (m_cyc != n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc: reached cyc %0d, wanted %0d", m_cyc, n);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        int len, sel;
        repeat (3) step();
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_valid", {3'b000, key_valid}, 4'h0);

        // Key 9 (row 2, col 1) held from reset release.
        keys = 16'h0200;
        rst  = 1'b1;
        wait_cyc(0);  chk("scan_c0", col_n, 4'b1110);
        wait_cyc(4);  chk("scan_c1", col_n, 4'b1101);
        wait_cyc(8);  chk("scan_c2", col_n, 4'b1011);
        wait_cyc(12); chk("scan_c3", col_n, 4'b0111);
        chk("early_valid", {3'b000, key_valid}, 4'h0);
        chk("early_held", {3'b000, key_held}, 4'h0);
        wait_cyc(31); chk("pre_confirm_valid", {3'b000, key_valid}, 4'h0);
        wait_cyc(32);
        chk("k9_valid", {3'b000, key_valid}, 4'h1);
        chk("k9_code", key_code, 4'd9);
        chk("k9_held", {3'b000, key_held}, 4'h1);
        wait_cyc(40); key_ready = 1'b1;
        wait_cyc(41); key_ready = 1'b0;
        chk("k9_accepted", {3'b000, key_valid}, 4'h0);
        wait_cyc(48); keys = '0;

        // Key 0, release, key 15 without consuming: overrun.
        wait_cyc(96);  keys = 16'h0001;
        wait_cyc(128);
        chk("k0_valid", {3'b000, key_valid}, 4'h1);
        chk("k0_code", key_code, 4'd0);
        keys = '0;
        wait_cyc(176); keys = 16'h8000;
        wait_cyc(208);
        chk("ovr_pulse", {3'b000, overrun}, 4'h1);
        chk("ovr_code", key_code, 4'd0);
        key_ready = 1'b1;
        wait_cyc(209);
        chk("ovr_one_cycle", {3'b000, overrun}, 4'h0);
        key_ready = 1'b0;
        keys = '0;

        // Key 5 confirmed, then reset while it is pending.
        wait_cyc(256); keys = 16'h0020;
        wait_cyc(288); chk("k5_code", key_code, 4'd5);
        wait_cyc(298);
        rst = 1'b0;
        #1;
        chk("mid_rst_col_n", col_n, 4'b1110);
        chk("mid_rst_code", key_code, 4'd0);
        chk("mid_rst_valid", {3'b000, key_valid}, 4'h0);
        chk("mid_rst_held", {3'b000, key_held}, 4'h0);
        keys = 16'h0040;
        repeat (3) step();
        rst = 1'b1;
        wait_cyc(20);
        rst = 1'b0;
        #1;
        chk("press_db_rst_col_n", col_n, 4'b1110);
        repeat (2) step();
        rst = 1'b1;
        wait_cyc(31); chk("restart_not_yet", {3'b000, key_valid}, 4'h0);
        wait_cyc(32);
        chk("k6_valid", {3'b000, key_valid}, 4'h1);
        chk("k6_code", key_code, 4'd6);

        // Random key patterns and random consumer readiness.
        for (int s = 0; s < 140; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      keys = '0;
            else if (sel < 8) keys = 16'h0001 << $urandom_range(0, 15);
            else              keys = (16'h0001 << $urandom_range(0, 15)) |
                                     (16'h0001 << $urandom_range(0, 15));
            len = $urandom_range(6, 80);
            for (int c = 0; c < len; c++) begin
                step();
                key_ready = ($urandom_range(0, 5) == 0);
            end
        end
        keys = '0;
        key_ready = 1'b1;
        repeat (80) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
